// File: rtl/alu_iterative_pkg.sv
// Shared types and constants for the iterative execute unit.
package alu_pkg;

  typedef enum logic [4:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } alu_fn_t;

  typedef enum logic [1:0] {
    IDLE, CALC, DONE
  } state_t;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_RSVD  = 2'b11;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // r_type is opcode bit 5: set for register-register ops.
  function automatic alu_fn_t decode_fn(input logic [1:0] alu_op,
                                        input logic       r_type,
                                        input logic [6:0] funct7,
                                        input logic [2:0] funct3);
    alu_fn_t fn;
    fn = ADD;
    case (alu_op)
      ALU_OP_SUB: fn = SUB;
      ALU_OP_FUNCT: begin
        if (r_type && funct7 == FUNCT7_MULDIV) begin
          case (funct3)
            3'b000:  fn = MUL;
            3'b001:  fn = MULH;
            3'b010:  fn = MULHSU;
            3'b011:  fn = MULHU;
            3'b100:  fn = DIV;
            3'b101:  fn = DIVU;
            3'b110:  fn = REM;
            default: fn = REMU;
          endcase
        end else begin
          case (funct3)
            3'b000:  fn = (r_type && funct7[5]) ? SUB : ADD;
            3'b001:  fn = SLL;
            3'b010:  fn = SLT;
            3'b011:  fn = SLTU;
            3'b100:  fn = XOR;
            3'b101:  fn = funct7[5] ? SRA : SRL;
            3'b110:  fn = OR;
            default: fn = AND;
          endcase
        end
      end
      default: fn = ADD;
    endcase
    return fn;
  endfunction

  function automatic logic is_mul_fn(input alu_fn_t fn);
    return fn inside {MUL, MULH, MULHSU, MULHU};
  endfunction

  function automatic logic is_div_fn(input alu_fn_t fn);
    return fn inside {DIV, DIVU, REM, REMU};
  endfunction

endpackage

// File: rtl/alu_iterative_if.sv
// Issue/result handshake bundle between the pipeline and the execute unit.
interface alu_iterative_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [1:0]      alu_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, opcode, funct7, funct3, alu_op, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, opcode, funct7, funct3, alu_op, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_iterative_mul_div_iter.sv
// Bit-serial multiply/divide on operand magnitudes with sign fix-up.
module mul_div_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  alu_fn_t         fn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int unsigned CW = $clog2(XLEN);

  logic            busy;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, mcand;
  logic            is_div, sel_alt, neg_q, neg_r;

  logic            a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic            div_ok;
  logic [XLEN-1:0] hi_n, lo_n;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] quo_s, rem_s;

  // Operand magnitudes and the sign treatment implied by the function.
  always_comb begin
    a_signed = fn inside {MUL, MULH, MULHSU, DIV, REM};
    b_signed = fn inside {MUL, MULH, DIV, REM};
    neg_a    = a_signed & a[XLEN-1];
    neg_b    = b_signed & b[XLEN-1];
    a_mag    = neg_a ? -a : a;
    b_mag    = neg_b ? -b : b;
  end

  // One shift-add or restoring-subtract step; hi/lo are product or remainder/quotient.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand};
    div_ok    = ~div_diff[XLEN];
    if (is_div) begin
      hi_n = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], div_ok};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  // Result is taken from the final step's next-state so it lands on the last counted edge.
  always_comb begin
    done   = busy && (cnt == '0);
    prod_s = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    quo_s  = neg_q ? -lo_n : lo_n;
    rem_s  = neg_r ? -hi_n : hi_n;
    if (is_div) result = sel_alt ? rem_s : quo_s;
    else        result = sel_alt ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
  end

  // Load on start, then iterate until the counter expires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      is_div  <= 1'b0;
      sel_alt <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= CW'(XLEN - 1);
      hi      <= '0;
      lo      <= a_mag;
      mcand   <= b_mag;
      is_div  <= is_div_fn(fn);
      sel_alt <= fn inside {MULH, MULHSU, MULHU, REM, REMU};
      neg_q   <= neg_a ^ neg_b;
      neg_r   <= neg_a;
    end else if (busy) begin
      hi <= hi_n;
      lo <= lo_n;
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_iterative.sv
// Execute unit: ALU-control decode, single-cycle ALU and iterative MUL/DIV.
module alu_iterative
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input logic            clk,
  input logic            rst_n,
  alu_iterative_if.slave bus
);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  alu_fn_t         fn;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0] alu_res, special_res, imm_res, md_result;
  logic            div_zero, div_ovf, needs_iter, md_start, md_done;
  logic            unused_opcode;

  assign unused_opcode = ^{bus.opcode[6], bus.opcode[4:0]};

  assign fn    = decode_fn(bus.alu_op, bus.opcode[5], bus.funct7, bus.funct3);
  assign shamt = bus.op_b[SHAMT_W-1:0];

  // Single-cycle ALU on the presented operands.
  always_comb begin
    case (fn)
      SUB:     alu_res = bus.op_a - bus.op_b;
      SLL:     alu_res = bus.op_a << shamt;
      SLT:     alu_res = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
      SLTU:    alu_res = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
      XOR:     alu_res = bus.op_a ^ bus.op_b;
      SRL:     alu_res = bus.op_a >> shamt;
      SRA:     alu_res = $signed(bus.op_a) >>> shamt;
      OR:      alu_res = bus.op_a | bus.op_b;
      AND:     alu_res = bus.op_a & bus.op_b;
      default: alu_res = bus.op_a + bus.op_b;
    endcase
  end

  // Divide-by-zero and signed overflow resolve without iterating.
  always_comb begin
    div_zero = (bus.op_b == '0);
    div_ovf  = (fn == DIV || fn == REM) && (bus.op_a == MOST_NEG) && (bus.op_b == '1);
    if (div_zero) special_res = (fn inside {DIV, DIVU}) ? '1 : bus.op_a;
    else          special_res = (fn == DIV) ? bus.op_a : '0;
    needs_iter = is_mul_fn(fn) || (is_div_fn(fn) && !div_zero && !div_ovf);
    imm_res    = is_div_fn(fn) ? special_res : alu_res;
    md_start   = (state == IDLE) && bus.in_valid && needs_iter;
  end

  mul_div_iter #(.XLEN(XLEN)) u_mul_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .fn     (fn),
    .a      (bus.op_a),
    .b      (bus.op_b),
    .done   (md_done),
    .result (md_result)
  );

  // Handshake FSM with registered result, zero and ready/valid outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.zero      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.in_ready <= 1'b0;
            if (needs_iter) begin
              state <= CALC;
            end else begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.result    <= imm_res;
              bus.zero      <= (imm_res == '0);
            end
          end
        end
        CALC: begin
          if (md_done) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.result    <= md_result;
            bus.zero      <= (md_result == '0);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Next-generation execute unit. Merges ALU-control decode with the arithmetic datapath. Adds the full RV32I ALU set and the RV32M multiply/divide set.
- Single-cycle ops return a registered result. MUL/DIV ops iterate one bit per cycle.
- Valid/ready handshakes on input and output, so the pipeline can stall around the multi-cycle ops.
- Sits between decode/register-read and writeback. The branch comparator consumes `zero`.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, ≥8.
- SHAMT_W, $clog2(XLEN), shift-amount bits taken from op_b.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept; high only in IDLE
- opcode  in  7  instruction opcode; bit 5 distinguishes R-type (1) from I-type (0)
- funct7  in  7  instruction funct7
- funct3  in  3  instruction funct3
- alu_op  in  2  from main control: 00 add (ld/st), 01 sub (branch), 10 decode funct fields, 11 reserved → add
- op_a  in  XLEN  operand A
- op_b  in  XLEN  operand B (register or immediate)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  operation result, held stable while out_valid && !out_ready
- zero  out  1  result == 0, valid with out_valid

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE, in_ready=1, out_valid=0, result=0, zero=1.
  - Any in-flight operation is abandoned and no result is emitted.
- Decode when alu_op=10:
  - M-op iff opcode[5]=1 and funct7=0000001. funct3 then selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Otherwise funct3 selects: 000 ADD, or SUB when opcode[5]=1 and funct7[5]=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7[5]=1 (I- and R-type alike); 110 OR; 111 AND.
- Shifts use op_b[SHAMT_W-1:0] only. SLT/SLTU produce 0 or 1, zero-extended.
- FSM states: IDLE, CALC, DONE.
  - IDLE: accept when in_valid && in_ready. Operands and decoded op are latched at acceptance; later input changes are ignored.
  - IDLE → DONE: single-cycle op, or DIV/REM special case. out_valid rises the next cycle (latency 1).
  - IDLE → CALC: multiply or divide. Counter loads XLEN-1.
  - CALC: one shift-add (multiply) or one restoring subtract (divide) step per cycle. Move to DONE when counter==0. out_valid is high XLEN+1 cycles after acceptance.
  - DONE: out_valid=1, in_ready=0. Go to IDLE on out_ready. No new op is accepted in the same cycle as the hand-off; minimum issue interval is 2 cycles.
- Multiply:
  - 2·XLEN-bit product computed on magnitudes, sign applied at completion.
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned treatment respectively.
- Divide:
  - Runs on magnitudes. Quotient sign = sign(a) xor sign(b). Remainder takes the sign of the dividend. Truncation toward zero.
- Divide special cases, detected in IDLE with no iteration:
  - Divisor = 0: quotient = all ones; remainder = op_a.
  - Signed overflow (op_a = most-negative, op_b = −1, DIV/REM): quotient = op_a; remainder = 0.
- in_valid while busy is ignored; the upstream stage must hold the operation.
- out_ready while out_valid=0 has no effect.
- All arithmetic wraps modulo 2^XLEN.

Decomposition:
- Shared package alu_pkg:
  - enum alu_fn_t (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
  - localparams for alu_op codes, OPCODE_OP/OPCODE_OP_IMM, FUNCT7_MULDIV.
- One sub-module, mul_div_iter: the iterative datapath (magnitude conversion, counter, accumulator/remainder registers, sign fix-up). It uses its own start/done pulse.
- Decode and single-cycle ALU stay in the top module.

Test Plan (XLEN=32):
- ADD/SUB: alu_op=10, opcode=0110011, funct3=000, funct7=0100000, a=5, b=7 → one cycle after accept, result=0xFFFFFFFE, zero=0. Same with alu_op=01, a=b=9 → result=0, zero=1.
- Shifts and compares: SRAI (opcode=0010011, funct7[5]=1), a=0x80000000, b=0x00000024 (shamt=4) → 0xF8000000. SLTU a=1, b=0xFFFFFFFF → 1. SLT same operands → 0.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF → 0x00000000. MULHU same operands → 0xFFFFFFFE. MUL a=3, b=−4 → 0xFFFFFFF4. out_valid rises exactly 33 cycles after accept; in_ready low throughout.
- Division: DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF. DIVU 7/0 → 0xFFFFFFFF (latency 1); REM 7/0 → 7. DIV 0x80000000/−1 → 0x80000000; REM of the same → 0.
- Back-pressure: hold out_ready=0 for 5 cycles after a DIV completes → result stable, in_ready=0, second in_valid ignored. Raise out_ready → IDLE next cycle, then accept the second op.
- Reset mid-CALC: drop rst_n at cycle 10 of a MUL → next edge: out_valid=0, result=0, in_ready=1. No stale result ever appears.
